// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the pipelined ripple-carry adder family.
//   DEF_WIDTH / DEF_SEG : default operand width and bits resolved per stage
//   ceil_div            : integer ceiling division, used to size the pipeline
//   seg_width           : width of the ripple segment handled by a given stage
//   stage_ctl_t         : width-independent part of a pipeline stage register
//                         (valid, carry into the next segment, operand sign bits)
package adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Every stage handles seg bits except the last, which takes whatever is left.
  function automatic int seg_width(input int width, input int seg, input int stage);
    int stages;
    stages = ceil_div(width, seg);
    if (stage == stages - 1) return width - (stages - 1) * seg;
    return seg;
  endfunction

  // The operand MSBs are captured at acceptance so the overflow decision at
  // the output does not need the full operands to travel down the pipe.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctl_t;

endpackage

// File: rtl/rca_fa.sv
// rca_fa
// Full-adder cell built from two half adders.
//   a, b, cin : input bits
//   sum       : a + b + cin, low bit
//   cout      : a + b + cin, carry bit
module rca_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p_sum;
  logic p_carry;
  logic g_carry;

  rca_ha u_ha0 (.a(a),     .b(b),   .sum(p_sum), .carry(p_carry));
  rca_ha u_ha1 (.a(p_sum), .b(cin), .sum(sum),   .carry(g_carry));

  // The two half-adder carries can never both be set, so OR is exact.
  assign cout = p_carry | g_carry;

endmodule

// File: rtl/rca_ha.sv
// rca_ha
// Half-adder cell.
//   a, b  : input bits
//   sum   : a xor b
//   carry : a and b
module rca_ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/rca_seg.sv
// rca_seg
// Combinational W-bit ripple-carry segment made of full-adder cells.
//   a, b : W-bit operands
//   cin  : carry into bit 0
//   sum  : W-bit sum
//   cout : carry out of bit W-1
module rca_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    rca_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[W];

endmodule

// File: rtl/rca_pipe.sv
// rca_pipe
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit operation is split
// into SEG-bit ripple segments, one per pipeline stage; the last stage
// register is the output register.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid, in_ready  : input handshake (in_ready = pipeline may advance)
//   sub                 : 0 = a + b + c_in, 1 = a - b (c_in ignored)
//   a, b, c_in          : operands and carry in
//   out_valid, out_ready: output handshake
//   res, c_out, ovf     : result mod 2^WIDTH, carry out (sub: 1 = no borrow),
//                         two's-complement overflow
module rca_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = ceil_div(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;

  // Stage registers. a_q/b_q hold the operand bits not yet added, shifted
  // down so the next stage always reads its segment from bit 0.
  stage_ctl_t       ctl_q [STAGES];
  logic [WIDTH-1:0] res_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];

  stage_ctl_t       ctl_d [STAGES];
  logic [WIDTH-1:0] res_d [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // One global stall: nothing moves while a result waits on the consumer.
  assign advance  = !ctl_q[LAST].valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + 1, so it reuses the adder with a forced carry.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : c_in;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int W  = seg_width(WIDTH, SEG, s);
    localparam int LO = s * SEG;

    stage_ctl_t       ctl_prev;
    logic [WIDTH-1:0] res_prev;
    logic [WIDTH-1:0] a_prev;
    logic [WIDTH-1:0] b_prev;
    logic [W-1:0]     seg_sum;
    logic             seg_cout;
    logic [WIDTH-1:0] res_nxt;

    // Stage 0 is fed straight from the transformed inputs; a bubble enters
    // whenever the pipe advances without an operand.
    if (s == 0) begin : g_first
      assign ctl_prev = '{valid: in_valid, carry: cin_eff,
                          a_msb: a[WIDTH-1], b_msb: b_eff[WIDTH-1]};
      assign res_prev = '0;
      assign a_prev   = a;
      assign b_prev   = b_eff;
    end else begin : g_next
      assign ctl_prev = ctl_q[s-1];
      assign res_prev = res_q[s-1];
      assign a_prev   = a_q[s-1];
      assign b_prev   = b_q[s-1];
    end

    rca_seg #(.W(W)) u_seg (
      .a    (a_prev[W-1:0]),
      .b    (b_prev[W-1:0]),
      .cin  (ctl_prev.carry),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    // Drop this stage's segment into its slot of the partial result.
    always_comb begin
      res_nxt           = res_prev;
      res_nxt[LO +: W]  = seg_sum;
    end

    assign ctl_d[s] = '{valid: ctl_prev.valid, carry: seg_cout,
                        a_msb: ctl_prev.a_msb, b_msb: ctl_prev.b_msb};
    assign res_d[s] = res_nxt;
    assign a_d[s]   = a_prev >> SEG;
    assign b_d[s]   = b_prev >> SEG;
  end

  // Reset wins over advance and wipes every stage, data included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        ctl_q[s] <= '0;
        res_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
      end
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        ctl_q[s] <= ctl_d[s];
        res_q[s] <= res_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
      end
    end
  end

  assign out_valid = ctl_q[LAST].valid;
  assign res       = res_q[LAST];
  assign c_out     = ctl_q[LAST].carry;
  assign ovf       = (ctl_q[LAST].a_msb == ctl_q[LAST].b_msb) &&
                     (res_q[LAST][WIDTH-1] != ctl_q[LAST].a_msb);

endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe
// Self-checking bench for rca_pipe. Two instances share the clock and reset:
// index 0 is the default 32/8 geometry, index 1 the odd 15/4 geometry.
module tb_rca_pipe;

  typedef struct {
    int          d;
    bit          sub;
    logic [31:0] a;
    logic [31:0] b;
    bit          cin;
    logic [31:0] res;
    bit          cout;
    bit          ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    bit          cout;
    bit          ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0]       sub;
  logic [1:0][31:0] a_v;
  logic [1:0][31:0] b_v;
  logic [1:0]       cin;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [31:0]      res_wide;
  logic [14:0]      res_odd;
  logic [1:0]       cout;
  logic [1:0]       ovf;

  rca_pipe #(.WIDTH(32), .SEG(8)) dut_wide (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sub(sub[0]), .a(a_v[0]), .b(b_v[0]), .c_in(cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .res(res_wide), .c_out(cout[0]), .ovf(ovf[0])
  );

  rca_pipe #(.WIDTH(15), .SEG(4)) dut_odd (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sub(sub[1]), .a(a_v[1][14:0]), .b(b_v[1][14:0]), .c_in(cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .res(res_odd), .c_out(cout[1]), .ovf(ovf[1])
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_cnt = 0;
  bit   bp_rand = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t held[2];
  bit   held_flag[2];
  vec_t tbl[11];

  function automatic logic [31:0] get_res(input int d);
    return (d == 0) ? res_wide : {17'd0, res_odd};
  endfunction

  // Reference: plain integer arithmetic on the true unsigned and signed values.
  function automatic exp_t ref_model(input int d, input bit s, input logic [31:0] a,
                                     input logic [31:0] b, input bit ci);
    longint lim, half, ua, ub, sa, sb, full, sres;
    exp_t   e;
    lim  = longint'(1) << ((d == 0) ? 32 : 15);
    half = lim / 2;
    ua   = longint'(a) & (lim - 1);
    ub   = longint'(b) & (lim - 1);
    sa   = (ua >= half) ? ua - lim : ua;
    sb   = (ub >= half) ? ub - lim : ub;
    if (s) begin
      full   = ua - ub;
      e.cout = (ua >= ub);
      sres   = sa - sb;
    end else begin
      full   = ua + ub + longint'(ci);
      e.cout = (full >= lim);
      sres   = sa + sb + longint'(ci);
    end
    e.res = 32'(full & (lim - 1));
    e.ovf = (sres < -half) || (sres >= half);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Present one operation and hold it until accepted; optionally queue its result.
  task automatic applyStimulus(input int d, input bit s, input logic [31:0] aa,
                               input logic [31:0] bb, input bit ci, input bit track,
                               input exp_t e);
    int guard;
    bit done;
    sub[d] = s; a_v[d] = aa; b_v[d] = bb; cin[d] = ci; in_valid[d] = 1'b1;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready[d]) begin
        if (track) begin
          if (d == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 200) begin
        n_cmp++; n_bad++;
        $display("[TB] FAIL accept_timeout_d%0d: got no accept, expected accept within 200 cycles", d);
        done = 1'b1;
      end
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic checkIdle(input int d, input string tag);
    checkOutput($sformatf("%s_out_valid_d%0d", tag, d), 32'(out_valid[d]), 32'd0);
    checkOutput($sformatf("%s_res_d%0d", tag, d), get_res(d), 32'd0);
    checkOutput($sformatf("%s_c_out_d%0d", tag, d), 32'(cout[d]), 32'd0);
    checkOutput($sformatf("%s_ovf_d%0d", tag, d), 32'(ovf[d]), 32'd0);
    checkOutput($sformatf("%s_in_ready_d%0d", tag, d), 32'(in_ready[d]), 32'd1);
  endtask

  // Called right after the accept edge: out_valid must rise after exactly
  // `stages` edges counting the accept edge itself.
  task automatic checkLatency(input int d, input int stages);
    for (int i = 0; i < stages; i++) begin
      @(negedge clk);
      checkOutput($sformatf("latency_d%0d_edge%0d", d, i), 32'(out_valid[d]),
                  32'(i == stages - 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL drain: got %0d/%0d results outstanding, expected 0/0", q0.size(), q1.size());
    end
  endtask

  // Output monitor: handshake rule, hold-while-stalled, in-order scoreboard.
  initial begin
    held_flag[0] = 1'b0;
    held_flag[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        if (rst) begin
          held_flag[d] = 1'b0;
          continue;
        end
        checkOutput($sformatf("in_ready_d%0d", d), 32'(in_ready[d]),
                    32'(!(out_valid[d] && !out_ready[d])));
        if (d == 0 && !in_ready[0]) stall_cnt++;
        if (held_flag[d]) begin
          checkOutput($sformatf("hold_valid_d%0d", d), 32'(out_valid[d]), 32'd1);
          checkOutput($sformatf("hold_res_d%0d", d), get_res(d), held[d].res);
          checkOutput($sformatf("hold_cout_d%0d", d), 32'(cout[d]), 32'(held[d].cout));
          checkOutput($sformatf("hold_ovf_d%0d", d), 32'(ovf[d]), 32'(held[d].ovf));
        end
        if (out_valid[d] && out_ready[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL unexpected_output_d%0d: got res %h, expected no output", d, get_res(d));
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput($sformatf("res_d%0d", d), get_res(d), e.res);
            checkOutput($sformatf("c_out_d%0d", d), 32'(cout[d]), 32'(e.cout));
            checkOutput($sformatf("ovf_d%0d", d), 32'(ovf[d]), 32'(e.ovf));
          end
        end
        held_flag[d] = out_valid[d] && !out_ready[d];
        held[d]      = '{get_res(d), cout[d], ovf[d]};
      end
    end
  end

  // Random consumer back-pressure, only while enabled.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (bp_rand) begin
        out_ready[0] = ($urandom_range(0, 3) != 0);
        out_ready[1] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    exp_t e;
    tbl[0]  = '{0, 1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0};
    tbl[1]  = '{0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3]  = '{0, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[4]  = '{0, 1'b1, 32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
    tbl[5]  = '{0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[6]  = '{0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[7]  = '{0, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[8]  = '{1, 1'b0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[9]  = '{1, 1'b0, 32'h0000_3FFF, 32'h0000_0001, 1'b0, 32'h0000_4000, 1'b0, 1'b1};
    tbl[10] = '{1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_7FFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = '0; sub = '0; a_v = '0; b_v = '0; cin = '0; out_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkIdle(0, "reset");
    checkIdle(1, "reset");
    @(posedge clk); #1;

    $display("[TB] first-op latency");
    applyStimulus(0, 1'b0, 32'd5, 32'd7, 1'b0, 1'b1, '{32'h0000_000C, 1'b0, 1'b0});
    checkLatency(0, 4);
    applyStimulus(1, 1'b0, 32'd3, 32'd4, 1'b0, 1'b1, '{32'd7, 1'b0, 1'b0});
    checkLatency(1, 4);

    $display("[TB] directed vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].d, tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1,
                    '{tbl[i].res, tbl[i].cout, tbl[i].ovf});
    end
    drain();

    $display("[TB] back-pressure stream");
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          e = ref_model(0, 1'b0, 32'(i), 32'(2 * i), 1'b0);
          applyStimulus(0, 1'b0, 32'(i), 32'(2 * i), 1'b0, 1'b1, e);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready[0] = 1'b1;
      end
    join
    drain();
    checkOutput("stall_cycles", 32'(stall_cnt), 32'd3);

    $display("[TB] reset mid-flight");
    applyStimulus(0, 1'b0, 32'd10, 32'd20, 1'b0, 1'b0, '{32'd0, 1'b0, 1'b0});
    applyStimulus(0, 1'b0, 32'd30, 32'd40, 1'b0, 1'b0, '{32'd0, 1'b0, 1'b0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdle(0, "midreset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("flushed_valid_%0d", i), 32'(out_valid[0]), 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1, '{32'd2, 1'b0, 1'b0});
    checkLatency(0, 4);
    drain();

    $display("[TB] random sweep with random back-pressure");
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int          d;
      bit          s, ci;
      logic [31:0] ra, rb;
      d  = int'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (d == 1) begin
        ra = ra & 32'h0000_7FFF;
        rb = rb & 32'h0000_7FFF;
      end
      e = ref_model(d, s, ra, rb, ci);
      applyStimulus(d, s, ra, rb, ci, 1'b1, e);
    end
    bp_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 2'b11;
    drain();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
